regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Param DATA_W, default 16: register and data-port width in bits.
REQ-002 Param ADDR_W, default 4: address width; NUM_REGS = 2**ADDR_W.
REQ-003 Param ZERO_REG, default 1: when 1, register 0 reads zero, ignores writes and is never busy.
REQ-004 Param BYPASS, default 1: when 1, a same-cycle write is forwarded to matching reads.
REQ-005 clk  in  1  the single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-low.
REQ-007 rd_addr1, rd_addr2  in  ADDR_W  read-port addresses.
REQ-008 rd_data1, rd_data2  out  DATA_W  read data, combinational, never high-Z.
REQ-009 rd_busy1, rd_busy2  out  1  busy bit of the addressed register, including same-cycle clear and set effects.
REQ-010 wr_en  in  1; wr_addr  in  ADDR_W; wr_data  in  DATA_W  writeback port.
REQ-011 iss_en  in  1; iss_addr  in  ADDR_W  reserves a destination register (sets its busy bit).
REQ-012 iss_stall  out  1  the reservation is refused this cycle.
REQ-013 flush  in  1  synchronous clear of all busy bits.
REQ-014 busy_vec  out  NUM_REGS  registered busy bits.
REQ-015 busy_cnt  out  ADDR_W+1  registered population count of busy_vec.

Function
REQ-016 Write: if wr_en and the target is not zero-register-protected, regs[wr_addr] takes wr_data at the next edge.
REQ-017 Read: rd_dataN = 0 if ZERO_REG and rd_addrN==0; else wr_data if BYPASS, wr_en and wr_addr==rd_addrN; else regs[rd_addrN].
REQ-018 With BYPASS=0, a read of the register being written returns the old value; the new value is visible in the next cycle.
REQ-019 Busy clear: wr_en clears busy[wr_addr] at the next edge.
REQ-020 iss_stall = iss_en and busy[iss_addr] and not (wr_en and wr_addr==iss_addr); it is 0 when iss_addr==0 and ZERO_REG=1.
REQ-021 Busy set: iss_en and not iss_stall sets busy[iss_addr] at the next edge, except for register 0 when ZERO_REG=1 (no-op, no stall).
REQ-022 Same register cleared by wr_en and set by an accepted iss_en in the same cycle: the set wins and the bit stays 1.
REQ-023 flush has priority over everything else: all busy bits go to 0 and busy_cnt to 0 at the next edge; the register write in the same cycle still completes.
REQ-024 busy_cnt tracks busy_vec exactly every cycle; it can never exceed NUM_REGS or drop below 0.
REQ-025 rd_busyN = (busy[rd_addrN] and not a same-cycle wr_en clear of rd_addrN) when BYPASS=1; when BYPASS=0 it is the raw busy[rd_addrN].
REQ-026 No data latency beyond the above; the scoreboard has one-cycle latency from iss_en to busy_vec.

Reset
REQ-027 rst low asynchronously clears all registers to 0, busy_vec to 0 and busy_cnt to 0.
REQ-028 While rst is low, wr_en, iss_en and flush are ignored; iss_stall reads 0.
REQ-029 After deassertion, the first edge with rst high performs normal updates.

Structure
REQ-030 Default widths and the reset data value live in the shared core package; NUM_REGS is derived locally.
REQ-031 One sub-module, rf_scoreboard, holds busy_vec, busy_cnt and the stall logic; the storage array and read muxes stay in regfile_scoreboard.
REQ-032 No tristate drivers on any port.

Verification
REQ-033 Reset, write reg3=0xBEEF, then read rd_addr1=3 -> 0xBEEF; write reg0=0x1234, then read reg0 -> 0x0000.
REQ-034 BYPASS=1: wr_en, reg5, 0xA5A5 with rd_addr2=5 in the same cycle -> rd_data2=0xA5A5 that cycle; BYPASS=0 -> old value, then 0xA5A5 next cycle.
REQ-035 iss reg7 -> busy_vec[7]=1 and busy_cnt=1; iss reg7 again -> iss_stall=1, busy_cnt stays 1; wr reg7 together with iss reg7 -> no stall, busy_vec[7] stays 1.
REQ-036 Reserve regs 1..15 in consecutive cycles -> busy_cnt=15; assert flush together with wr reg2=0x0042 -> busy_cnt=0, reg2=0x0042.
REQ-037 Reserve reg9, write reg4=0x1111, pull rst low mid-cycle -> busy_vec=0 and reg4 reads 0 immediately, without waiting for a clock edge.
REQ-038 Random mix of iss/wr/flush checked against a reference model: busy_cnt equals the popcount of busy_vec every cycle.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// Shared core defaults for the register file / scoreboard slice.
// Also holds the read-source selector that the read muxes use.
package regfile_scoreboard_pkg;

  localparam int unsigned CORE_DATA_W   = 16;
  localparam int unsigned CORE_ADDR_W   = 4;
  localparam bit          CORE_ZERO_REG = 1'b1;
  localparam bit          CORE_BYPASS   = 1'b1;

  // Reset value of every architectural register; truncated to DATA_W at use.
  localparam logic [63:0] CORE_RST_DATA = 64'h0;

  typedef enum logic [1:0] {
    SrcZero   = 2'd0,
    SrcBypass = 2'd1,
    SrcArray  = 2'd2
  } rd_src_e;

  // Hardwired zero beats forwarding, forwarding beats the stored value.
  function automatic rd_src_e rd_src_sel(input logic zero_hit, input logic byp_hit);
    if (zero_hit) begin
      return SrcZero;
    end
    if (byp_hit) begin
      return SrcBypass;
    end
    return SrcArray;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_scb.sv
// Busy-bit scoreboard: reservation bits, their registered population count
// and the issue-stall decision.
module rf_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned ADDR_W   = CORE_ADDR_W,
  parameter bit          ZERO_REG = CORE_ZERO_REG,
  parameter bit          BYPASS   = CORE_BYPASS
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_en,
  input  logic [ADDR_W-1:0]      i_wr_addr,
  input  logic                   i_iss_en,
  input  logic [ADDR_W-1:0]      i_iss_addr,
  input  logic                   i_flush,
  input  logic [ADDR_W-1:0]      i_rd_addr1,
  input  logic [ADDR_W-1:0]      i_rd_addr2,
  output logic                   o_rd_busy1,
  output logic                   o_rd_busy2,
  output logic                   o_iss_stall,
  output logic [(2**ADDR_W)-1:0] o_busy_vec,
  output logic [ADDR_W:0]        o_busy_cnt
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_d;
  logic [ADDR_W:0]     r_busy_cnt;
  logic [ADDR_W:0]     w_busy_cnt_d;

  logic w_wr_ok;
  logic w_iss_ok;
  logic w_iss_zero;
  logic w_wr_hits_iss;
  logic w_clr_rd1;
  logic w_clr_rd2;
  logic w_stall;

  // Ports are ignored while reset is held, including their combinational effects.
  assign w_wr_ok       = i_wr_en & i_rst_n;
  assign w_iss_ok      = i_iss_en & i_rst_n;
  assign w_iss_zero    = ZERO_REG && (i_iss_addr == '0);
  assign w_wr_hits_iss = w_wr_ok && (i_wr_addr == i_iss_addr);

  assign w_stall     = w_iss_ok & r_busy[i_iss_addr] & ~w_wr_hits_iss & ~w_iss_zero;
  assign o_iss_stall = w_stall;

  assign w_clr_rd1 = w_wr_ok && (i_wr_addr == i_rd_addr1);
  assign w_clr_rd2 = w_wr_ok && (i_wr_addr == i_rd_addr2);

  assign o_rd_busy1 = r_busy[i_rd_addr1] & ~(BYPASS & w_clr_rd1);
  assign o_rd_busy2 = r_busy[i_rd_addr2] & ~(BYPASS & w_clr_rd2);

  // Clear first so an accepted set on the same register wins.
  always_comb begin
    w_busy_d = r_busy;
    if (w_wr_ok) begin
      w_busy_d[i_wr_addr] = 1'b0;
    end
    if (w_iss_ok && !w_stall && !w_iss_zero) begin
      w_busy_d[i_iss_addr] = 1'b1;
    end
    if (ZERO_REG) begin
      w_busy_d[0] = 1'b0;
    end
    if (i_flush) begin
      w_busy_d = '0;
    end
  end

  // Count is computed from the next-state vector so it tracks busy_vec exactly.
  always_comb begin
    w_busy_cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_busy_cnt_d = w_busy_cnt_d + {{ADDR_W{1'b0}}, w_busy_d[i]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_d;
      r_busy_cnt <= w_busy_cnt_d;
    end
  end

  assign o_busy_vec = r_busy;
  assign o_busy_cnt = r_busy_cnt;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port and an
// attached busy-bit scoreboard for destination reservation.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W   = CORE_DATA_W,
  parameter int unsigned ADDR_W   = CORE_ADDR_W,
  parameter bit          ZERO_REG = CORE_ZERO_REG,
  parameter bit          BYPASS   = CORE_BYPASS
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [ADDR_W-1:0]      i_rd_addr1,
  input  logic [ADDR_W-1:0]      i_rd_addr2,
  output logic [DATA_W-1:0]      o_rd_data1,
  output logic [DATA_W-1:0]      o_rd_data2,
  output logic                   o_rd_busy1,
  output logic                   o_rd_busy2,
  input  logic                   i_wr_en,
  input  logic [ADDR_W-1:0]      i_wr_addr,
  input  logic [DATA_W-1:0]      i_wr_data,
  input  logic                   i_iss_en,
  input  logic [ADDR_W-1:0]      i_iss_addr,
  output logic                   o_iss_stall,
  input  logic                   i_flush,
  output logic [(2**ADDR_W)-1:0] o_busy_vec,
  output logic [ADDR_W:0]        o_busy_cnt
);

  localparam int unsigned       NUM_REGS = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] RST_VAL  = DATA_W'(CORE_RST_DATA);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic    w_wr_ok;
  logic    w_wr_we;
  rd_src_e w_src1;
  rd_src_e w_src2;

  assign w_wr_ok = i_wr_en & i_rst_n;
  assign w_wr_we = w_wr_ok && !(ZERO_REG && (i_wr_addr == '0));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RST_VAL;
      end
    end else if (w_wr_we) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  assign w_src1 = rd_src_sel(ZERO_REG && (i_rd_addr1 == '0),
                             BYPASS && w_wr_ok && (i_wr_addr == i_rd_addr1));
  assign w_src2 = rd_src_sel(ZERO_REG && (i_rd_addr2 == '0),
                             BYPASS && w_wr_ok && (i_wr_addr == i_rd_addr2));

  always_comb begin
    o_rd_data1 = r_regs[i_rd_addr1];
    unique case (w_src1)
      SrcZero:   o_rd_data1 = '0;
      SrcBypass: o_rd_data1 = i_wr_data;
      default:   o_rd_data1 = r_regs[i_rd_addr1];
    endcase
  end

  always_comb begin
    o_rd_data2 = r_regs[i_rd_addr2];
    unique case (w_src2)
      SrcZero:   o_rd_data2 = '0;
      SrcBypass: o_rd_data2 = i_wr_data;
      default:   o_rd_data2 = r_regs[i_rd_addr2];
    endcase
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scb (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wr_en    (i_wr_en),
    .i_wr_addr  (i_wr_addr),
    .i_iss_en   (i_iss_en),
    .i_iss_addr (i_iss_addr),
    .i_flush    (i_flush),
    .i_rd_addr1 (i_rd_addr1),
    .i_rd_addr2 (i_rd_addr2),
    .o_rd_busy1 (o_rd_busy1),
    .o_rd_busy2 (o_rd_busy2),
    .o_iss_stall(o_iss_stall),
    .o_busy_vec (o_busy_vec),
    .o_busy_cnt (o_busy_cnt)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and model-checked bench; runs a forwarding and a non-forwarding
// instance side by side from the same stimulus.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [3:0]  rd_addr1, rd_addr2;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        iss_en;
  logic [3:0]  iss_addr;
  logic        flush;

  logic [15:0] a_rd_data1, a_rd_data2, b_rd_data1, b_rd_data2;
  logic        a_rd_busy1, a_rd_busy2, b_rd_busy1, b_rd_busy2;
  logic        a_stall, b_stall;
  logic [15:0] a_busy_vec, b_busy_vec;
  logic [4:0]  a_busy_cnt, b_busy_cnt;

  int unsigned n_cmp;
  int unsigned n_err;

  logic [15:0] m_busy;
  logic [15:0] m_regs [16];

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd_addr1(rd_addr1), .i_rd_addr2(rd_addr2),
    .o_rd_data1(a_rd_data1), .o_rd_data2(a_rd_data2),
    .o_rd_busy1(a_rd_busy1), .o_rd_busy2(a_rd_busy2),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_iss_en(iss_en), .i_iss_addr(iss_addr), .o_iss_stall(a_stall),
    .i_flush(flush), .o_busy_vec(a_busy_vec), .o_busy_cnt(a_busy_cnt)
  );

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd_addr1(rd_addr1), .i_rd_addr2(rd_addr2),
    .o_rd_data1(b_rd_data1), .o_rd_data2(b_rd_data2),
    .o_rd_busy1(b_rd_busy1), .o_rd_busy2(b_rd_busy2),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_iss_en(iss_en), .i_iss_addr(iss_addr), .o_iss_stall(b_stall),
    .i_flush(flush), .o_busy_vec(b_busy_vec), .o_busy_cnt(b_busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    iss_en = 1'b0;
    flush  = 1'b0;
  endtask

  initial begin
    logic        r_stall;
    logic [15:0] r_exp;
    logic [15:0] r_next;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    rd_addr1 = '0; rd_addr2 = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    #2 rst_n = 1'b0;
    tick();
    check_eq("rst_busy_vec", 32'(a_busy_vec), 32'h0);
    check_eq("rst_busy_cnt", 32'(a_busy_cnt), 32'h0);

    // Requests while in reset must be ignored.
    iss_en = 1'b1; iss_addr = 4'd7; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hDEAD;
    rd_addr1 = 4'd3;
    #1;
    check_eq("rst_stall", 32'(a_stall), 32'h0);
    check_eq("rst_no_bypass", 32'(a_rd_data1), 32'h0);
    tick();
    check_eq("rst_iss_ignored", 32'(a_busy_vec), 32'h0);
    check_eq("rst_wr_ignored", 32'(a_rd_data1), 32'h0);
    idle();
    rst_n = 1'b1;

    // Basic write then read, zero register protection.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
    tick();
    idle(); rd_addr1 = 4'd3;
    #1;
    check_eq("rd_reg3", 32'(a_rd_data1), 32'hBEEF);
    check_eq("rd_reg3_nb", 32'(b_rd_data1), 32'hBEEF);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1234; rd_addr1 = 4'd0;
    #1;
    check_eq("rd_reg0_bypass", 32'(a_rd_data1), 32'h0);
    tick();
    idle();
    #1;
    check_eq("rd_reg0", 32'(a_rd_data1), 32'h0);

    // Same-cycle forwarding versus old value.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hA5A5; rd_addr2 = 4'd5;
    #1;
    check_eq("bypass_rd2", 32'(a_rd_data2), 32'hA5A5);
    check_eq("nobypass_rd2_old", 32'(b_rd_data2), 32'h0);
    tick();
    idle();
    #1;
    check_eq("nobypass_rd2_new", 32'(b_rd_data2), 32'hA5A5);

    // Reservation, stall, clear+set collision.
    iss_en = 1'b1; iss_addr = 4'd7;
    #1;
    check_eq("iss7_no_stall", 32'(a_stall), 32'h0);
    tick();
    idle();
    check_eq("iss7_vec", 32'(a_busy_vec), 32'h0080);
    check_eq("iss7_cnt", 32'(a_busy_cnt), 32'h1);
    iss_en = 1'b1; iss_addr = 4'd7; rd_addr1 = 4'd7;
    #1;
    check_eq("iss7_again_stall", 32'(a_stall), 32'h1);
    check_eq("rd_busy1_set", 32'(a_rd_busy1), 32'h1);
    tick();
    idle();
    check_eq("iss7_again_cnt", 32'(a_busy_cnt), 32'h1);
    iss_en = 1'b1; iss_addr = 4'd7; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h7777;
    #1;
    check_eq("wr_iss7_no_stall", 32'(a_stall), 32'h0);
    check_eq("rd_busy1_clr_byp", 32'(a_rd_busy1), 32'h0);
    check_eq("rd_busy1_raw_nb", 32'(b_rd_busy1), 32'h1);
    tick();
    idle();
    check_eq("wr_iss7_vec", 32'(a_busy_vec), 32'h0080);
    check_eq("wr_iss7_cnt", 32'(a_busy_cnt), 32'h1);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0707;
    tick();
    idle();
    check_eq("wr7_clear_vec", 32'(a_busy_vec), 32'h0);
    check_eq("wr7_clear_cnt", 32'(a_busy_cnt), 32'h0);
    iss_en = 1'b1; iss_addr = 4'd0;
    #1;
    check_eq("iss0_no_stall", 32'(a_stall), 32'h0);
    tick();
    idle();
    check_eq("iss0_never_busy", 32'(a_busy_vec), 32'h0);

    // Fill the scoreboard, then flush alongside a write.
    for (int i = 1; i < 16; i++) begin
      iss_en = 1'b1; iss_addr = 4'(i);
      tick();
    end
    idle();
    check_eq("fill_cnt", 32'(a_busy_cnt), 32'd15);
    check_eq("fill_vec", 32'(a_busy_vec), 32'hFFFE);
    flush = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h0042;
    iss_en = 1'b1; iss_addr = 4'd3;
    tick();
    idle();
    rd_addr1 = 4'd2;
    #1;
    check_eq("flush_cnt", 32'(a_busy_cnt), 32'h0);
    check_eq("flush_vec", 32'(a_busy_vec), 32'h0);
    check_eq("flush_wr_reg2", 32'(a_rd_data1), 32'h0042);

    // Asynchronous reset in the middle of a cycle.
    iss_en = 1'b1; iss_addr = 4'd9;
    tick();
    idle();
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h1111;
    tick();
    idle();
    rd_addr1 = 4'd4;
    #1;
    check_eq("pre_rst_vec", 32'(a_busy_vec), 32'h0200);
    check_eq("pre_rst_reg4", 32'(a_rd_data1), 32'h1111);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_vec", 32'(a_busy_vec), 32'h0);
    check_eq("async_rst_cnt", 32'(a_busy_cnt), 32'h0);
    check_eq("async_rst_reg4", 32'(a_rd_data1), 32'h0);
    tick();
    rst_n = 1'b1;

    // Random traffic against a reference model.
    m_busy = '0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    for (int c = 0; c < 300; c++) begin
      iss_en   = ($urandom_range(0, 1) == 1);
      iss_addr = 4'($urandom_range(0, 15));
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_addr  = 4'($urandom_range(0, 15));
      wr_data  = 16'($urandom);
      flush    = ($urandom_range(0, 15) == 0);
      rd_addr1 = 4'($urandom_range(0, 15));
      #1;
      r_stall = iss_en && m_busy[iss_addr] && !(wr_en && wr_addr == iss_addr) && iss_addr != 0;
      if (rd_addr1 == 4'd0) r_exp = '0;
      else if (wr_en && wr_addr == rd_addr1) r_exp = wr_data;
      else r_exp = m_regs[rd_addr1];
      check_eq("rnd_stall", 32'(a_stall), 32'(r_stall));
      check_eq("rnd_rd1", 32'(a_rd_data1), 32'(r_exp));
      r_next = m_busy;
      if (wr_en) r_next[wr_addr] = 1'b0;
      if (iss_en && !r_stall && iss_addr != 0) r_next[iss_addr] = 1'b1;
      if (flush) r_next = '0;
      if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
      m_busy = r_next;
      tick();
      check_eq("rnd_busy_vec", 32'(a_busy_vec), 32'(m_busy));
      check_eq("rnd_busy_cnt", 32'(a_busy_cnt), 32'($countones(m_busy)));
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
